// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sipo4_if.sv
// gf180mcu_fd_sc_mcu9t5v0__sipo4_if: serial-in and parallel-out handshake bundle for the sipo4 expander.
interface gf180mcu_fd_sc_mcu9t5v0__sipo4_if;
    logic D;
    logic DV;
    logic DR;
    logic Q1;
    logic Q2;
    logic Q3;
    logic Q4;
    logic QV;
    logic QR;
    logic ZN;
    modport master (output D, DV, QR, input DR, Q1, Q2, Q3, Q4, QV, ZN);
    modport slave (input D, DV, QR, output DR, Q1, Q2, Q3, Q4, QV, ZN);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sipo4.sv
// gf180mcu_fd_sc_mcu9t5v0__sipo4: 1-to-4 serial-in/parallel-out expander with valid/ready handshakes.
// Define GF180MCU_FD_SC_MCU9T5V0__SIPO4_ZDET_EN to drive ZN as the NOR of the held word.
module gf180mcu_fd_sc_mcu9t5v0__sipo4 (
    input logic CLK,
    input logic RN,
    gf180mcu_fd_sc_mcu9t5v0__sipo4_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state;
    logic [1:0] cnt;
    logic [2:0] s;
    logic [3:0] q;
    logic s_xfer;
    logic p_xfer;
    logic last;
    // Only the 4th bit stalls, and only while the held word is not being taken this cycle.
    assign bus.DR = !(cnt == 2'd3 && state == FULL && !bus.QR);
    assign s_xfer = bus.DV & bus.DR;
    assign p_xfer = (state == FULL) & bus.QR;
    assign last = s_xfer & (cnt == 2'd3);
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= EMPTY;
            cnt <= 2'd0;
            s <= 3'd0;
            q <= 4'd0;
        end else begin
            if (s_xfer) cnt <= cnt + 2'd1;
            if (s_xfer && !last) s <= {cnt == 2'd2 ? bus.D : s[2], cnt == 2'd1 ? bus.D : s[1], cnt == 2'd0 ? bus.D : s[0]};
            if (last) q <= {bus.D, s};
            state <= last ? FULL : (p_xfer ? EMPTY : state);
        end
    end
    assign bus.QV = (state == FULL);
    assign bus.Q1 = q[0];
    assign bus.Q2 = q[1];
    assign bus.Q3 = q[2];
    assign bus.Q4 = q[3];
`ifdef GF180MCU_FD_SC_MCU9T5V0__SIPO4_ZDET_EN
    assign bus.ZN = ~|q;
`else
    assign bus.ZN = 1'b0;
`endif
endmodule
